stream_demux2: RTL and testbench
================================

// Module: stream_demux2
//
// PURPOSE
// - Buffered 1:2 stream demultiplexer; the inverse of the team's 8-bit 2:1 select mux.
// - A single valid/ready input stream carries data_i plus sel_i.
// - Each accepted word is steered to output channel A (sel_i=0) or B (sel_i=1).
// - Each channel has its own FIFO, so one stalled consumer does not block the
//   other channel until that channel's FIFO fills.
// - Sits between a single producer and two independent downstream consumers.
//
// PARAMETERS
// WIDTH  8  data word width in bits
// DEPTH  4  entries per channel FIFO; power of 2, >= 2
//
// PORTS
// clk_i       in   1                  clock, all state on rising edge
// rst_ni      in   1                  reset, asynchronous, active-low
// in_valid_i  in   1                  producer has a word
// in_ready_o  out  1                  word is accepted this cycle if in_valid_i
// data_i      in   WIDTH              input word
// sel_i       in   1                  destination: 0 = A, 1 = B; qualified by in_valid_i
// a_valid_o   out  1                  channel A head word valid
// a_ready_i   in   1                  channel A consumer takes head
// a_o         out  WIDTH              channel A head word
// a_count_o   out  $clog2(DEPTH+1)    words held in channel A
// b_valid_o   out  1                  channel B head word valid
// b_ready_i   in   1                  channel B consumer takes head
// b_o         out  WIDTH              channel B head word
// b_count_o   out  $clog2(DEPTH+1)    words held in channel B
//
// BEHAVIOUR
// - Reset (rst_ni=0, asynchronous):
//   - pointers, counts and storage are cleared to 0; a_o = b_o = 0.
//   - a_valid_o = b_valid_o = 0.
//   - in_ready_o = 1 as soon as the reset is released (both FIFOs empty).
// - Accept: in_ready_o = !full[sel_i].
//   - This is combinational from sel_i only; it never depends on a_ready_i or b_ready_i.
//   - Push into the FIFO selected by sel_i on a rising edge where in_valid_i & in_ready_o.
// - Full FIFO: no push, even if the same channel pops in the same cycle. The word waits.
// - Cross-channel independence: if A is full, a word with sel_i=1 is still accepted when B
//   is not full. There is no head-of-line blocking across channels for words at the input.
// - Output: x_valid_o = (x_count_o != 0). x_o is the FIFO head; it is stable while
//   x_valid_o & !x_ready_i.
// - Pop on a rising edge where x_valid_o & x_ready_i. x_ready_i while empty is ignored.
// - Latency: a word pushed at edge N is visible at edge N (x_valid_o high in cycle N+1) when
//   its FIFO was empty. There is no combinational path from input to output.
// - Simultaneous push and pop on the same non-full channel: count is unchanged, and both
//   pointers advance.
// - Ordering is FIFO within a channel. There is no ordering relation between channels.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is kept separately,
//   range 0..DEPTH.
// - Reset mid-operation: all buffered words are discarded, and outputs return to their
//   reset values immediately.
// - A word is never dropped or duplicated. Total pops never exceed total pushes per channel.
//
// STRUCTURE
// - Package stream_demux_pkg:
//   - typedef enum logic {CH_A=1'b0, CH_B=1'b1} chan_e;
//   - localparam DEF_WIDTH = 8;
//   - localparam DEF_DEPTH = 4.
// - Sub-module sync_fifo #(WIDTH, DEPTH):
//   - ports clk_i, rst_ni, push_i, wdata_i, pop_i, rdata_o, full_o, empty_o, count_o.
//   - Instantiated twice (u_fifo_a, u_fifo_b).
// - Top-level: push/ready steering from sel_i, plus valid/count wiring only.
//
// TESTING
// - Reset then idle:
//   - in_ready_o=1, a_valid_o=b_valid_o=0, counts=0, a_o=b_o=0.
// - Push 0x11 (sel=0), then 0x22 (sel=1), both consumers ready:
//   - a_o=0x11 valid one cycle after its push edge; b_o=0x22 likewise; counts return to 0.
// - a_ready_i=0, push 0xA0..0xA3 to A:
//   - a_count_o=4.
//   - A 5th word with sel=0 gives in_ready_o=0.
//   - The same cycle with sel=1 gives in_ready_o=1, and 0xB0 reaches b_o.
// - A full, a_ready_i=1 and push sel=0 in the same cycle:
//   - no push, a_count_o 4->3.
//   - Next cycle accepts; drains in order 0xA0,0xA1,0xA2,0xA3,new.
// - Steady push+pop on B, count=2:
//   - count stays 2 over 10 cycles; pointers wrap past DEPTH; data order preserved.
// - Assert rst_ni mid-stream with A=3, B=1 words:
//   - valids drop immediately, counts=0.
//   - After release, the old words never appear.
// - Random run: sel/valid/ready each random, 2000 cycles.
//   - Scoreboard per channel: no loss, no duplication, order preserved.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the buffered 1:2 stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

endpackage

// File: rtl/stream_demux2_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count; head word is always on rdata_o.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even when it pops in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata_i;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata_o = mem[rptr];
    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign count_o = count;

endmodule

// File: rtl/stream_demux2.sv
// Buffered 1:2 stream demultiplexer: each accepted word is steered by sel_i
// into the channel A or channel B FIFO; the channels drain independently.
module stream_demux2
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       sel_i,
    output logic                       a_valid_o,
    input  logic                       a_ready_i,
    output logic [WIDTH-1:0]           a_o,
    output logic [$clog2(DEPTH+1)-1:0] a_count_o,
    output logic                       b_valid_o,
    input  logic                       b_ready_i,
    output logic [WIDTH-1:0]           b_o,
    output logic [$clog2(DEPTH+1)-1:0] b_count_o
);

    chan_e sel_ch;
    logic  a_full;
    logic  b_full;
    logic  a_empty;
    logic  b_empty;
    logic  accept;
    logic  push_a;
    logic  push_b;
    logic  pop_a;
    logic  pop_b;

    assign sel_ch = chan_e'(sel_i);

    // Ready looks only at the selected channel, so a full A never stalls B traffic.
    assign in_ready_o = (sel_ch == CH_B) ? ~b_full : ~a_full;
    assign accept     = in_valid_i & in_ready_o;
    assign push_a     = accept & (sel_ch == CH_A);
    assign push_b     = accept & (sel_ch == CH_B);

    assign a_valid_o = ~a_empty;
    assign b_valid_o = ~b_empty;
    assign pop_a     = a_valid_o & a_ready_i;
    assign pop_b     = b_valid_o & b_ready_i;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_a),
        .wdata_i (data_i),
        .pop_i   (pop_a),
        .rdata_o (a_o),
        .full_o  (a_full),
        .empty_o (a_empty),
        .count_o (a_count_o)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_b),
        .wdata_i (data_i),
        .pop_i   (pop_b),
        .rdata_o (b_o),
        .full_o  (b_full),
        .empty_o (b_empty),
        .count_o (b_count_o)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// Randomized and directed bench for stream_demux2 against a per-channel queue model.
module tb_stream_demux2;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] data = '0;
    logic             sel = 1'b0;
    logic             a_valid_o;
    logic             a_ready = 1'b0;
    logic [WIDTH-1:0] a_o;
    logic [CW-1:0]    a_count_o;
    logic             b_valid_o;
    logic             b_ready = 1'b0;
    logic [WIDTH-1:0] b_o;
    logic [CW-1:0]    b_count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];

    always #5 clk = ~clk;

    stream_demux2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .data_i     (data),
        .sel_i      (sel),
        .a_valid_o  (a_valid_o),
        .a_ready_i  (a_ready),
        .a_o        (a_o),
        .a_count_o  (a_count_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready),
        .b_o        (b_o),
        .b_count_o  (b_count_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare against the queue model, then advance the model.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br);
        bit rdy, acc, pa, pb;
        in_valid = v; sel = s; data = d; a_ready = ar; b_ready = br;
        #1;
        rdy = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        check("in_ready", int'(in_ready_o), int'(rdy));
        check("a_valid", int'(a_valid_o), int'(qa.size() != 0));
        check("b_valid", int'(b_valid_o), int'(qb.size() != 0));
        check("a_count", int'(a_count_o), qa.size());
        check("b_count", int'(b_count_o), qb.size());
        if (qa.size() != 0) check("a_data", int'(a_o), int'(qa[0]));
        if (qb.size() != 0) check("b_data", int'(b_o), int'(qb[0]));
        acc = v && rdy;
        pa  = ar && (qa.size() != 0);
        pb  = br && (qb.size() != 0);
        @(posedge clk);
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ar, input logic br);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, ar, br);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_valid", int'(a_valid_o), 0);
        check("rst_b_valid", int'(b_valid_o), 0);
        check("rst_a_count", int'(a_count_o), 0);
        check("rst_b_count", int'(b_count_o), 0);
        check("rst_a_o", int'(a_o), 0);
        check("rst_b_o", int'(b_o), 0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", int'(in_ready_o), 1);
        @(negedge clk);
        idle(2, 1'b1, 1'b1);

        // One word to each channel with both consumers ready
        step(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        check("lat_a_o", int'(a_o), 'h11);
        check("lat_a_valid", int'(a_valid_o), 1);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        check("lat_b_o", int'(b_o), 'h22);
        idle(2, 1'b1, 1'b1);

        // Fill A, then show B still accepts
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
        check("a_full_count", int'(a_count_o), 4);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
        check("b0_head", int'(b_o), 'hB0);

        // Full A with pop and push in the same cycle: no push
        step(1'b1, 1'b0, 8'hA4, 1'b1, 1'b1);
        check("a_full_pop_count", int'(a_count_o), 3);
        step(1'b1, 1'b0, 8'hA4, 1'b0, 1'b1);
        check("a_refill_count", int'(a_count_o), 4);
        idle(6, 1'b1, 1'b1);

        // Steady push+pop on B at occupancy 2, wrapping the pointers
        step(1'b1, 1'b1, 8'hC0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hC1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'hC2 + i), 1'b1, 1'b1);
            check("b_steady_count", int'(b_count_o), 2);
        end
        idle(3, 1'b1, 1'b1);

        // Reset mid-stream with A=3, B=1
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0);
        check("pre_rst_a_count", int'(a_count_o), 3);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", int'(a_valid_o), 0);
        check("mid_rst_b_valid", int'(b_valid_o), 0);
        check("mid_rst_a_count", int'(a_count_o), 0);
        check("mid_rst_b_count", int'(b_count_o), 0);
        check("mid_rst_a_o", int'(a_o), 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1, 1'b1);

        // Random traffic: slow consumers first to exercise full FIFOs, then fast
        for (int i = 0; i < 2000; i++) begin
            logic ar, br;
            if (i < 1000) begin
                ar = ($urandom_range(0, 2) == 0);
                br = ($urandom_range(0, 2) == 0);
            end else begin
                ar = ($urandom_range(0, 3) != 0);
                br = ($urandom_range(0, 3) != 0);
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), ar, br);
        end
        idle(2 * DEPTH + 2, 1'b1, 1'b1);
        check("drain_a_empty", qa.size(), 0);
        check("drain_b_empty", qb.size(), 0);
        check("drain_a_count", int'(a_count_o), 0);
        check("drain_b_count", int'(b_count_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
